cache_cmd_dispatch: RTL and testbench

- Front-end stage directly upstream of the L2 cache controller.
- Accepts raw trace commands (code + 32-bit address) from the trace reader, validates and classifies them, and buffers them in a small in-order FIFO.
- Splits each address into tag/index/offset and presents one decoded request at a time to the cache over a valid/ready handshake.
- Holds maintenance commands (clear, print) until the cache reports idle, and keeps per-class statistics counters.

---
 rtl/cache_pkg.sv | 37 +++
 rtl/cache_cmd_dispatch_fifo.sv | 54 +++++
 rtl/cache_cmd_dispatch.sv | 148 ++++++++++++++
 tb/tb_cache_cmd_dispatch.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Command codes, address-field defaults and classification helpers shared by the
// dispatcher and the L2 cache controller.
package cache_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int INDEX_W_DEF  = 14;
  localparam int OFFSET_W_DEF = 6;

  localparam logic [3:0] CMD_RD_DATA  = 4'd0;
  localparam logic [3:0] CMD_WR_DATA  = 4'd1;
  localparam logic [3:0] CMD_RD_INSTR = 4'd2;
  localparam logic [3:0] CMD_SNP_INV  = 4'd3;
  localparam logic [3:0] CMD_SNP_RD   = 4'd4;
  localparam logic [3:0] CMD_SNP_WR   = 4'd5;
  localparam logic [3:0] CMD_SNP_RWIM = 4'd6;
  localparam logic [3:0] CMD_CLEAR    = 4'd8;
  localparam logic [3:0] CMD_PRINT    = 4'd9;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PRESENT,
    ST_WAIT_IDLE
  } disp_state_t;

  function automatic logic is_snoop(input logic [3:0] code);
    return (code >= CMD_SNP_INV) && (code <= CMD_SNP_RWIM);
  endfunction

  function automatic logic is_maint(input logic [3:0] code);
    return (code == CMD_CLEAR) || (code == CMD_PRINT);
  endfunction

  function automatic logic is_legal(input logic [3:0] code);
    return (code <= CMD_SNP_RWIM) || is_maint(code);
  endfunction

endpackage

// File: rtl/cache_cmd_dispatch_fifo.sv
// In-order command buffer; writes land in one cycle, full blocks further pushes.
// Exposes the entry behind the head so a consumer can refill its register on the pop edge.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           next_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign next_data = mem[rd_ptr + PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cache_cmd_dispatch.sv
// Validates trace commands, buffers them in order and presents one registered request
// to the L2 at a time (earliest one cycle after acceptance); maintenance waits for cache_idle.
module cache_cmd_dispatch
  import cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int INDEX_W    = INDEX_W_DEF,
  parameter int OFFSET_W   = OFFSET_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [3:0]                          cmd_code,
  input  logic [ADDR_W-1:0]                   cmd_addr,
  output logic                                req_valid,
  input  logic                                req_ready,
  output logic [3:0]                          req_code,
  output logic [ADDR_W-INDEX_W-OFFSET_W-1:0]  req_tag,
  output logic [INDEX_W-1:0]                  req_index,
  output logic [OFFSET_W-1:0]                 req_offset,
  output logic                                req_snoop,
  output logic                                req_maint,
  input  logic                                cache_idle,
  output logic [CNT_W-1:0]                    stat_cpu_rd,
  output logic [CNT_W-1:0]                    stat_cpu_wr,
  output logic [CNT_W-1:0]                    stat_snoop,
  output logic [CNT_W-1:0]                    stat_illegal
);

  localparam int ENT_W = 4 + ADDR_W;
  localparam int FCW   = $clog2(FIFO_DEPTH+1);

  disp_state_t       state;
  disp_state_t       state_nxt;
  logic              ready_en;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_count;
  logic [ENT_W-1:0]  next_ent;
  logic [ENT_W-1:0]  head_q;
  logic [ENT_W-1:0]  load_ent;
  logic              load;
  logic [ADDR_W-1:0] head_addr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign cmd_ready = ready_en && !fifo_full;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && is_legal(cmd_code);
  assign req_valid = (state == ST_PRESENT);
  assign pop       = req_valid && req_ready && !fifo_empty;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({cmd_code, cmd_addr}),
    .pop       (pop),
    .next_data (next_ent),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The output register is refilled on the same edge it is consumed: from the entry
  // behind the head, or straight from the input when the buffer is about to drain.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_ent  = next_ent;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          load     = 1'b1;
          load_ent = {cmd_code, cmd_addr};
        end
      end
      ST_PRESENT: begin
        if (pop) begin
          if (fifo_count > FCW'(1)) begin
            load = 1'b1;
          end else if (push) begin
            load     = 1'b1;
            load_ent = {cmd_code, cmd_addr};
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (cache_idle) state_nxt = ST_PRESENT;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (load) state_nxt = is_maint(load_ent[ENT_W-1 -: 4]) ? ST_WAIT_IDLE : ST_PRESENT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      head_q   <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (load) head_q <= load_ent;
    end
  end

  assign req_code   = head_q[ENT_W-1 -: 4];
  assign head_addr  = head_q[ADDR_W-1:0];
  assign req_offset = head_addr[OFFSET_W-1:0];
  assign req_index  = head_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_tag    = head_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign req_snoop  = is_snoop(req_code);
  assign req_maint  = is_maint(req_code);

  // Statistics follow acceptance, so dropped and still-queued commands are both visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cpu_rd  <= '0;
      stat_cpu_wr  <= '0;
      stat_snoop   <= '0;
      stat_illegal <= '0;
    end else if (accept) begin
      if (!is_legal(cmd_code))
        stat_illegal <= sat_inc(stat_illegal);
      else if (cmd_code == CMD_RD_DATA || cmd_code == CMD_RD_INSTR)
        stat_cpu_rd <= sat_inc(stat_cpu_rd);
      else if (cmd_code == CMD_WR_DATA)
        stat_cpu_wr <= sat_inc(stat_cpu_wr);
      else if (is_snoop(cmd_code))
        stat_snoop <= sat_inc(stat_snoop);
    end
  end

endmodule

// File: tb/tb_cache_cmd_dispatch.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_cache_cmd_dispatch;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_code;
  logic [31:0] cmd_addr;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_code;
  logic [11:0] req_tag;
  logic [13:0] req_index;
  logic [5:0]  req_offset;
  logic        req_snoop;
  logic        req_maint;
  logic        cache_idle;
  logic [CW-1:0] stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  int          exp_code[$];
  logic [31:0] exp_addr[$];
  int          m_rd, m_wr, m_snp, m_ill;
  bit          prev_stall = 1'b0;
  logic [35:0] prev_fields;

  cache_cmd_dispatch #(
    .ADDR_W(32), .INDEX_W(14), .OFFSET_W(6), .FIFO_DEPTH(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_addr(cmd_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code), .req_tag(req_tag),
    .req_index(req_index), .req_offset(req_offset), .req_snoop(req_snoop), .req_maint(req_maint),
    .cache_idle(cache_idle),
    .stat_cpu_rd(stat_cpu_rd), .stat_cpu_wr(stat_cpu_wr), .stat_snoop(stat_snoop),
    .stat_illegal(stat_illegal)
  );

  always #5 clk = ~clk;

  function automatic bit m_legal(int c);
    return (c >= 0 && c <= 6) || c == 8 || c == 9;
  endfunction

  function automatic int m_sat(int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Reference model: legal accepted commands queue up and must leave in order.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_code.delete();
      exp_addr.delete();
      m_rd = 0; m_wr = 0; m_snp = 0; m_ill = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (req_valid !== 1'b1 || {req_code, req_tag, req_index, req_offset} !== prev_fields) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%b fields=%h want valid=1 fields=%h",
                   req_valid, {req_code, req_tag, req_index, req_offset}, prev_fields);
        end
      end
      if (req_valid === 1'b1) begin
        n_checks++;
        if (exp_code.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_req: code=%0d with empty model queue", req_code);
        end else begin
          if (int'(req_code) != exp_code[0] ||
              {20'd0, req_tag} !== (exp_addr[0] >> 20) ||
              {18'd0, req_index} !== ((exp_addr[0] >> 6) & 32'h3FFF) ||
              {26'd0, req_offset} !== (exp_addr[0] & 32'h3F) ||
              req_snoop !== (exp_code[0] >= 3 && exp_code[0] <= 6) ||
              req_maint !== (exp_code[0] == 8 || exp_code[0] == 9)) begin
            n_fail++;
            $display("FAIL req_order: got code=%0d tag=%h idx=%h off=%h snp=%b mnt=%b want code=%0d addr=%h",
                     req_code, req_tag, req_index, req_offset, req_snoop, req_maint,
                     exp_code[0], exp_addr[0]);
          end
          if (req_ready === 1'b1) begin
            void'(exp_code.pop_front());
            void'(exp_addr.pop_front());
          end
        end
      end
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        if (!m_legal(int'(cmd_code))) m_ill = m_sat(m_ill);
        else begin
          if (cmd_code == 0 || cmd_code == 2) m_rd = m_sat(m_rd);
          else if (cmd_code == 1) m_wr = m_sat(m_wr);
          else if (cmd_code >= 3 && cmd_code <= 6) m_snp = m_sat(m_snp);
          exp_code.push_back(int'(cmd_code));
          exp_addr.push_back(cmd_addr);
        end
      end
      prev_stall  = (req_valid === 1'b1) && (req_ready !== 1'b1);
      prev_fields = {req_code, req_tag, req_index, req_offset};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cmd_valid = 1'b0;
    cmd_code  = 4'bx;
    cmd_addr  = 32'bx;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    req_ready  = 1'b0;
    cache_idle = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    req_ready  = 1'b0;
    cache_idle = 1'b1;
    tick();
    tick();
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_checks++;
    if ({req_valid, req_code, req_tag, req_index, req_offset, req_snoop, req_maint} !== '0) begin
      n_fail++;
      $display("FAIL reset_req: got v=%b c=%h t=%h i=%h o=%h s=%b m=%b want all 0",
               req_valid, req_code, req_tag, req_index, req_offset, req_snoop, req_maint);
    end
    n_checks++;
    if ({stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_stats: got %h want 0", {stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_basic_decode;
    do_reset();
    req_ready = 1'b1;
    cmd_valid = 1'b1; cmd_code = 4'd0; cmd_addr = 32'h1234_5678;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", cmd_ready); end
    tick();
    idle_inputs();
    n_checks++;
    if (req_valid !== 1'b1 || req_code !== 4'd0 || req_tag !== 12'h123 || req_index !== 14'h1159 ||
        req_offset !== 6'h38 || req_snoop !== 1'b0 || req_maint !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_decode: got v=%b c=%h t=%h i=%h o=%h s=%b m=%b want v=1 c=0 t=123 i=1159 o=38 s=0 m=0",
               req_valid, req_code, req_tag, req_index, req_offset, req_snoop, req_maint);
    end
    n_checks++;
    if (stat_cpu_rd !== CW'(1)) begin n_fail++; $display("FAIL basic_stat_rd: got %0d want 1", stat_cpu_rd); end
    tick();
    n_checks++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b want 0", req_valid); end
  endtask

  task automatic test_backpressure;
    int          codes [5] = '{1, 4, 1, 4, 1};
    logic [31:0] a [5];
    int          seen_c[$];
    logic [31:0] seen_a[$];
    bit          acc;
    do_reset();
    for (int i = 0; i < 5; i++) a[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_code = 4'(codes[i]); cmd_addr = a[i];
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready%0d: got %b want 1", i, cmd_ready); end
      tick();
    end
    cmd_code = 4'(codes[4]); cmd_addr = a[4];
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", cmd_ready); end
      n_checks++;
      if (req_valid !== 1'b1 || req_code !== 4'd1 || {req_tag, req_index, req_offset} !== a[0]) begin
        n_fail++;
        $display("FAIL bp_head_stable: got v=%b c=%0d a=%h want v=1 c=1 a=%h",
                 req_valid, req_code, {req_tag, req_index, req_offset}, a[0]);
      end
      tick();
    end
    req_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && seen_c.size() < 5; cyc++) begin
      acc = cmd_valid && cmd_ready;
      if (req_valid === 1'b1) begin
        seen_c.push_back(int'(req_code));
        seen_a.push_back({req_tag, req_index, req_offset});
      end
      tick();
      if (acc) idle_inputs();
    end
    n_checks++;
    if (seen_c.size() != 5) begin
      n_fail++;
      $display("FAIL bp_drain_count: got %0d want 5", seen_c.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (seen_c[i] != codes[i] || seen_a[i] !== a[i]) begin
          n_fail++;
          $display("FAIL bp_drain_order%0d: got c=%0d a=%h want c=%0d a=%h", i, seen_c[i], seen_a[i], codes[i], a[i]);
        end
      end
    end
    n_checks++;
    if (stat_cpu_wr !== CW'(3) || stat_snoop !== CW'(2) || stat_cpu_rd !== '0 || stat_illegal !== '0) begin
      n_fail++;
      $display("FAIL bp_stats: got rd=%0d wr=%0d snp=%0d ill=%0d want 0 3 2 0",
               stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal);
    end
  endtask

  task automatic test_maint_hold;
    bit seen = 1'b0;
    do_reset();
    req_ready = 1'b1; cache_idle = 1'b0;
    cmd_valid = 1'b1; cmd_code = 4'd8; cmd_addr = $urandom;
    tick();
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (req_valid !== 1'b0) begin n_fail++; $display("FAIL maint_held%0d: got %b want 0", k, req_valid); end
      tick();
    end
    cache_idle = 1'b1;
    for (int k = 0; k < 2 && !seen; k++) begin
      tick();
      if (req_valid === 1'b1) begin
        seen = 1'b1;
        n_checks++;
        if (req_maint !== 1'b1 || req_code !== 4'd8) begin
          n_fail++;
          $display("FAIL maint_fields: got m=%b c=%0d want m=1 c=8", req_maint, req_code);
        end
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL maint_release: req_valid 0 after idle, want 1 within 2 cycles"); end
    n_checks++;
    if ({stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal} !== '0) begin
      n_fail++;
      $display("FAIL maint_stats: got %h want 0", {stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal});
    end
  endtask

  task automatic test_illegal;
    int codes [2] = '{7, 12};
    do_reset();
    req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; cmd_code = 4'(codes[i]); cmd_addr = $urandom;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready%0d: got %b want 1", i, cmd_ready); end
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (req_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_no_req: got %b want 0", req_valid); end
      tick();
    end
    n_checks++;
    if (stat_illegal !== CW'(2) || stat_cpu_rd !== '0 || stat_cpu_wr !== '0 || stat_snoop !== '0) begin
      n_fail++;
      $display("FAIL illegal_stats: got rd=%0d wr=%0d snp=%0d ill=%0d want 0 0 0 2",
               stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal);
    end
  endtask

  task automatic test_push_pop;
    int          codes [5] = '{0, 1, 5, 2, 4};
    logic [31:0] a [5];
    int          seen_c[$];
    logic [31:0] seen_a[$];
    do_reset();
    for (int i = 0; i < 5; i++) a[i] = $urandom;
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; cmd_code = 4'(codes[i]); cmd_addr = a[i];
      tick();
    end
    cmd_code = 4'(codes[2]); cmd_addr = a[2];
    req_ready = 1'b1;
    n_checks++;
    if (req_valid !== 1'b1 || req_code !== 4'd0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_setup: got v=%b c=%0d rdy=%b want v=1 c=0 rdy=1", req_valid, req_code, cmd_ready);
    end
    tick();
    req_ready = 1'b0;
    n_checks++;
    if (req_valid !== 1'b1 || req_code !== 4'd1 || {req_tag, req_index, req_offset} !== a[1]) begin
      n_fail++;
      $display("FAIL pp_new_head: got v=%b c=%0d a=%h want v=1 c=1 a=%h",
               req_valid, req_code, {req_tag, req_index, req_offset}, a[1]);
    end
    for (int i = 3; i < 5; i++) begin
      cmd_code = 4'(codes[i]); cmd_addr = a[i];
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL pp_refill%0d: got %b want 1", i, cmd_ready); end
      tick();
    end
    idle_inputs();
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL pp_count_full: got %b want 0", cmd_ready); end
    req_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && seen_c.size() < 4; cyc++) begin
      if (req_valid === 1'b1) begin
        seen_c.push_back(int'(req_code));
        seen_a.push_back({req_tag, req_index, req_offset});
      end
      tick();
    end
    n_checks++;
    if (seen_c.size() != 4) begin
      n_fail++;
      $display("FAIL pp_drain_count: got %0d want 4", seen_c.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (seen_c[i] != codes[i+1] || seen_a[i] !== a[i+1]) begin
          n_fail++;
          $display("FAIL pp_order%0d: got c=%0d a=%h want c=%0d a=%h", i, seen_c[i], seen_a[i], codes[i+1], a[i+1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int codes [3] = '{0, 1, 5};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_code = 4'(codes[i]); cmd_addr = $urandom;
      tick();
    end
    idle_inputs();
    n_checks++;
    if (req_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", req_valid); end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (req_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_in_reset: got v=%b rdy=%b want v=0 rdy=0", req_valid, cmd_ready);
    end
    n_checks++;
    if ({stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal} !== '0) begin
      n_fail++;
      $display("FAIL mid_stats: got %h want 0", {stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b want 1", cmd_ready); end
    req_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale%0d: got %b want 0", k, req_valid); end
      tick();
    end
  endtask

  task automatic test_random;
    int k;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b1;
        cmd_code  = 4'($urandom_range(0, 15));
        cmd_addr  = $urandom;
      end else begin
        idle_inputs();
      end
      req_ready  = ($urandom_range(0, 3) != 0);
      cache_idle = ($urandom_range(0, 2) != 0);
      tick();
    end
    idle_inputs();
    req_ready = 1'b1; cache_idle = 1'b1;
    k = 0;
    while (exp_code.size() > 0 && k < 40) begin
      tick();
      k++;
    end
    n_checks++;
    if (exp_code.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d commands left, want 0", exp_code.size());
    end
    n_checks++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rand_idle_valid: got %b want 0", req_valid); end
    n_checks++;
    if (int'(stat_cpu_rd) != m_rd || int'(stat_cpu_wr) != m_wr ||
        int'(stat_snoop) != m_snp || int'(stat_illegal) != m_ill) begin
      n_fail++;
      $display("FAIL rand_stats: got rd=%0d wr=%0d snp=%0d ill=%0d want %0d %0d %0d %0d",
               stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal, m_rd, m_wr, m_snp, m_ill);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    req_ready  = 1'b0;
    cache_idle = 1'b1;
    test_reset();
    test_basic_decode();
    test_backpressure();
    test_maint_hold();
    test_illegal();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
